// File: rtl/sonar_pkg.sv
// Shared defaults and types for the sonar channel sequencer.
// Holds channel/data/frame widths and the sequencer state enum.
package sonar_pkg;

  localparam int N_CH   = 8;
  localparam int DATA_W = 24;
  localparam int FRM_W  = 16;
  localparam int CH_W   = $clog2(N_CH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } seq_state_t;

endpackage

// File: rtl/chan_sequencer_axis_out_reg.sv
// axis_out_reg: single-entry AXI-Stream register slice (tdata/tuser/tlast).
// Ports: s_* load side, m_* drain side; s_ready_o = empty or draining.
module axis_out_reg #(
  parameter int DATA_W = 24,
  parameter int USER_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic [USER_W-1:0] s_user_i,
  input  logic              s_last_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic [USER_W-1:0] m_user_o,
  output logic              m_last_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [USER_W-1:0] user_q;
  logic              last_q;

  assign s_ready_o = !valid_q || m_ready_i;
  assign m_valid_o = valid_q;
  assign m_data_o  = data_q;
  assign m_user_o  = user_q;
  assign m_last_o  = last_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      user_q  <= '0;
      last_q  <= 1'b0;
    end else if (s_valid_i && s_ready_o) begin
      valid_q <= 1'b1;
      data_q  <= s_data_i;
      user_q  <= s_user_i;
      last_q  <= s_last_i;
    end else if (m_ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/chan_sequencer.sv
// chan_sequencer: round-robin N_CH-to-1 AXI-Stream interleaver with packets.
// Ports: s_axis_* per-channel inputs, m_axis_* tagged output, enable/busy/pkt_count.
module chan_sequencer
  import sonar_pkg::*;
#(
  parameter int N_CH   = sonar_pkg::N_CH,
  parameter int DATA_W = sonar_pkg::DATA_W,
  parameter int FRM_W  = sonar_pkg::FRM_W
) (
  input  logic                     s_axis_aclk,
  input  logic                     s_axis_aresetn,
  input  logic                     enable,
  input  logic [FRM_W-1:0]         pkt_frames,
  input  logic [N_CH*DATA_W-1:0]   s_axis_tdata,
  input  logic [N_CH-1:0]          s_axis_tvalid,
  output logic [N_CH-1:0]          s_axis_tready,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic [$clog2(N_CH)-1:0]  m_axis_tuser,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     busy,
  output logic [31:0]              pkt_count
);

  localparam int CW = $clog2(N_CH);

  seq_state_t        state_q;
  logic [CW-1:0]     ch_q;
  logic [FRM_W-1:0]  frm_q;
  logic [FRM_W-1:0]  frm_len_q;
  logic [31:0]       pkt_cnt_q;

  logic              out_rdy;
  logic              accept;
  logic              last_ch;
  logic              last_frm;
  logic              pkt_end;
  logic [FRM_W-1:0]  len_d;
  logic [DATA_W-1:0] ch_data;

  // A zero frame count would never reach a packet end; run it as one.
  assign len_d    = (pkt_frames == '0) ? FRM_W'(1) : pkt_frames;
  assign last_ch  = (ch_q == CW'(N_CH - 1));
  assign last_frm = (frm_q == frm_len_q - FRM_W'(1));
  assign pkt_end  = accept && last_ch && last_frm;
  assign ch_data  = s_axis_tdata[int'(ch_q)*DATA_W +: DATA_W];

  // Ready depends only on state, ch and the output slice: no tvalid path.
  assign accept = (state_q != IDLE) && out_rdy && s_axis_tvalid[ch_q];
  assign s_axis_tready = ((state_q != IDLE) && out_rdy)
                       ? (N_CH'(1) << ch_q) : '0;

  assign busy      = (state_q != IDLE);
  assign pkt_count = pkt_cnt_q;

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      frm_q     <= '0;
      frm_len_q <= FRM_W'(1);
      pkt_cnt_q <= '0;
    end else begin
      if (accept) begin
        if (last_ch) begin
          ch_q <= '0;
          if (last_frm) begin
            frm_q     <= '0;
            pkt_cnt_q <= pkt_cnt_q + 32'd1;
          end else begin
            frm_q <= frm_q + FRM_W'(1);
          end
        end else begin
          ch_q <= ch_q + CW'(1);
        end
      end
      unique case (state_q)
        IDLE: begin
          if (enable) begin
            frm_len_q <= len_d;
            state_q   <= RUN;
          end
        end
        RUN: begin
          if (pkt_end) begin
            if (!enable) state_q <= IDLE;
            else         frm_len_q <= len_d;
          end else if (!enable) begin
            state_q <= STOP;
          end
        end
        STOP: begin
          if (pkt_end)     state_q <= IDLE;
          else if (enable) state_q <= RUN;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  axis_out_reg #(
    .DATA_W (DATA_W),
    .USER_W (CW)
  ) u_out (
    .clk_i     (s_axis_aclk),
    .rst_ni    (s_axis_aresetn),
    .s_valid_i (accept),
    .s_ready_o (out_rdy),
    .s_data_i  (ch_data),
    .s_user_i  (ch_q),
    .s_last_i  (last_frm),
    .m_valid_o (m_axis_tvalid),
    .m_ready_i (m_axis_tready),
    .m_data_o  (m_axis_tdata),
    .m_user_o  (m_axis_tuser),
    .m_last_o  (m_axis_tlast)
  );

endmodule

// File: tb/tb_chan_sequencer.sv
// Self-checking bench for chan_sequencer: vector table plus corner sequences.
// Scoreboard queue filled on input handshakes, drained on output beats.
module tb_chan_sequencer;

  localparam int NC = 8;
  localparam int DW = 24;
  localparam int FW = 16;
  localparam int CW = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [FW-1:0]     pkt_frames;
  logic [NC*DW-1:0]  s_axis_tdata;
  logic [NC-1:0]     s_axis_tvalid;
  logic [NC-1:0]     s_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic [CW-1:0]     m_axis_tuser;
  logic              m_axis_tlast;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              busy;
  logic [31:0]       pkt_count;

  chan_sequencer dut (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rst_n),
    .enable         (enable),
    .pkt_frames     (pkt_frames),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tuser   (m_axis_tuser),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .busy           (busy),
    .pkt_count      (pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] u;
    logic          l;
  } beat_t;

  typedef struct {
    int frames;
    int beats;
    int pkts;
    int tlasts;
  } vec_t;

  beat_t       exp_q[$];
  vec_t        vecs[6];
  int          checks = 0;
  int          errors = 0;
  int          out_beats = 0;
  int          tl_cnt = 0;
  int          m_ch = 0;
  int          m_frm = 0;
  int          m_len = 1;
  logic [19:0] cnt[NC];
  int          vmode = 0;
  int          rdy_rnd = 0;
  int          hold2 = 0;
  int          pf = 1;
  logic        hold_v = 1'b0;
  logic [31:0] hold_b = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Input driver: bench-owned data {ch, seq}, valid/ready patterns.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int c = 0; c < NC; c++) begin
        s_axis_tdata[c*DW +: DW] = {4'(c), cnt[c]};
        if (vmode == 0) s_axis_tvalid[c] = 1'b1;
        else s_axis_tvalid[c] = ($urandom_range(3, 0) != 0);
        if (c == 2 && hold2 > 0) s_axis_tvalid[c] = 1'b0;
      end
      if (hold2 > 0) hold2--;
      m_axis_tready = (rdy_rnd != 0) ? ($urandom_range(9, 0) < 7) : 1'b1;
      pkt_frames = FW'(pf);
    end
  end

  // Monitor: handshakes seen at negedge complete on the next posedge.
  always @(negedge clk) begin : mon
    beat_t       e;
    logic [NC-1:0] acc;
    logic        tl;
    if (rst_n) begin
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: got beat %0h expected none",
                   m_axis_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("tdata", 32'(m_axis_tdata), 32'(e.d));
          chk("tuser", 32'(m_axis_tuser), 32'(e.u));
          chk("tlast", 32'(m_axis_tlast), 32'(e.l));
        end
        out_beats++;
        if (m_axis_tlast) tl_cnt++;
      end
      if (hold_v) begin
        chk("stall_valid", 32'(m_axis_tvalid), 32'd1);
        chk("stall_data", {4'd0, m_axis_tdata, m_axis_tuser, m_axis_tlast},
            hold_b);
      end
      hold_v = m_axis_tvalid && !m_axis_tready;
      hold_b = {4'd0, m_axis_tdata, m_axis_tuser, m_axis_tlast};
      if (s_axis_tready != '0)
        chk("tready_onehot", 32'(s_axis_tready), 32'(1) << m_ch);
      acc = s_axis_tready & s_axis_tvalid;
      if (acc != '0) begin
        if (m_ch == 0 && m_frm == 0) m_len = (pf == 0) ? 1 : pf;
        tl = (m_frm == m_len - 1);
        e.d = {4'(m_ch), cnt[m_ch]};
        e.u = CW'(m_ch);
        e.l = tl;
        exp_q.push_back(e);
        cnt[m_ch] = cnt[m_ch] + 20'd1;
        if (m_ch == NC - 1) begin
          m_ch = 0;
          if (tl) m_frm = 0;
          else m_frm++;
        end else begin
          m_ch++;
        end
      end
    end
  end

  task automatic clear_model();
    exp_q.delete();
    m_ch = 0;
    m_frm = 0;
    out_beats = 0;
    tl_cnt = 0;
    hold_v = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    chk({tag, "_tdata"}, 32'(m_axis_tdata), 32'd0);
    chk({tag, "_tuser"}, 32'(m_axis_tuser), 32'd0);
    chk({tag, "_tlast"}, 32'(m_axis_tlast), 32'd0);
    chk({tag, "_s_tready"}, 32'(s_axis_tready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_pkt_count"}, pkt_count, 32'd0);
  endtask

  task automatic do_reset();
    enable = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero("rst");
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_beats(input int n, input int limit, output int cyc);
    cyc = 0;
    while (out_beats < n && cyc < limit) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (out_beats < n) begin
      checks++;
      errors++;
      $display("FAIL wait_beats timeout: got %0d beats required %0d",
               out_beats, n);
    end
  endtask

  task automatic wait_idle(input int limit);
    int k;
    k = 0;
    while ((busy || m_axis_tvalid) && k < limit) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("idle_reached", 32'(busy || m_axis_tvalid), 32'd0);
  endtask

  initial begin
    int cyc;
    int bad;
    rst_n = 1'b0;
    enable = 1'b0;
    m_axis_tready = 1'b1;
    s_axis_tvalid = '0;
    s_axis_tdata = '0;
    pkt_frames = '0;
    for (int c = 0; c < NC; c++) cnt[c] = 20'(c * 4096);

    vecs[0] = '{33, 264, 1, 8};
    vecs[1] = '{33, 263, 0, 7};
    vecs[2] = '{0, 24, 3, 24};
    vecs[3] = '{1, 16, 2, 16};
    vecs[4] = '{2, 40, 2, 16};
    vecs[5] = '{3, 30, 1, 8};

    // Table: all valid, ready high, back-to-back beats.
    for (int i = 0; i < 6; i++) begin
      vmode = 0;
      rdy_rnd = 0;
      pf = vecs[i].frames;
      do_reset();
      @(posedge clk);
      #1;
      enable = 1'b1;
      wait_beats(vecs[i].beats, 2000, cyc);
      chk("throughput", 32'(cyc), 32'(vecs[i].beats + 2));
      chk("pkt_count", pkt_count, 32'(vecs[i].pkts));
      chk("tlast_count", 32'(tl_cnt), 32'(vecs[i].tlasts));
      chk("busy_run", 32'(busy), 32'd1);
    end

    // Random valid and ready, 10000 beats, then stop and drain.
    pf = 5;
    do_reset();
    vmode = 1;
    rdy_rnd = 1;
    @(posedge clk);
    #1;
    enable = 1'b1;
    wait_beats(10000, 60000, cyc);
    enable = 1'b0;
    wait_idle(3000);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    chk("pkt_align", 32'(out_beats % 40), 32'd0);
    chk("pkt_total", pkt_count, 32'(out_beats / 40));
    vmode = 0;
    rdy_rnd = 0;

    // Stop requested in frame 1 of a 4-frame packet.
    pf = 4;
    do_reset();
    @(posedge clk);
    #1;
    enable = 1'b1;
    wait_beats(11, 200, cyc);
    enable = 1'b0;
    wait_idle(200);
    chk("stop_beats", 32'(out_beats), 32'd32);
    chk("stop_tlasts", 32'(tl_cnt), 32'd8);
    chk("stop_pkt", pkt_count, 32'd1);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (s_axis_tready != '0) bad++;
    end
    chk("no_tready_after_stop", 32'(bad), 32'd0);

    // Reset mid-packet at frame 5, ch 3.
    pf = 8;
    do_reset();
    @(posedge clk);
    #1;
    enable = 1'b1;
    wait_beats(43, 300, cyc);
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    clear_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_beats(64, 500, cyc);
    chk("post_rst_pkt", pkt_count, 32'd1);
    chk("post_rst_tlasts", 32'(tl_cnt), 32'd8);

    // Channel 2 stalled for 50 cycles.
    pf = 4;
    do_reset();
    hold2 = 50;
    @(posedge clk);
    #1;
    enable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      #1;
    end
    chk("stall_beats", 32'(out_beats), 32'd2);
    chk("stall_tready", 32'(s_axis_tready), 32'h04);
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      #1;
      if (out_beats != 2) bad++;
    end
    chk("stall_blocked", 32'(bad), 32'd0);
    wait_beats(32, 300, cyc);
    chk("stall_pkt", pkt_count, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
